// File: rtl/cla_seq_pkg.sv
// Shared types and sizing helpers for the nibble-serial CLA adder.
package cla_seq_pkg;

  localparam int unsigned NIBBLE = 4;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StRun  = 2'd1,
    StDone = 2'd2
  } cla_seq_state_e;

  function automatic int unsigned cla_seq_steps(input int unsigned width);
    return width / NIBBLE;
  endfunction

  // Step counter needs at least one bit even when a single step suffices.
  function automatic int unsigned cla_seq_idx_w(input int unsigned width);
    int unsigned n;
    n = width / NIBBLE;
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/cla_seq_adder_cla.sv
// 4-bit carry-lookahead adder slice shared by cla_seq_adder.
module cla (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  output logic [3:0] sum,
  output logic       cout
);

  logic [3:0] w_g;
  logic [3:0] w_p;
  logic [4:0] w_c;

  always_comb begin
    w_g    = a & b;
    w_p    = a ^ b;
    w_c[0] = cin;
    w_c[1] = w_g[0] | (w_p[0] & cin);
    w_c[2] = w_g[1] | (w_p[1] & w_g[0]) | (w_p[1] & w_p[0] & cin);
    w_c[3] = w_g[2] | (w_p[2] & w_g[1]) | (w_p[2] & w_p[1] & w_g[0])
           | (w_p[2] & w_p[1] & w_p[0] & cin);
    w_c[4] = w_g[3] | (w_p[3] & w_g[2]) | (w_p[3] & w_p[2] & w_g[1])
           | (w_p[3] & w_p[2] & w_p[1] & w_g[0])
           | (w_p[3] & w_p[2] & w_p[1] & w_p[0] & cin);
    sum    = w_p ^ w_c[3:0];
    cout   = w_c[4];
  end

endmodule

// File: rtl/cla_seq_adder.sv
// Nibble-serial WIDTH-bit adder reusing one 4-bit CLA slice, LSB nibble first.
// Optional signed-overflow output enabled by defining CLA_SEQ_OVF_EN.
module cla_seq_adder
  import cla_seq_pkg::*;
#(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
`ifdef CLA_SEQ_OVF_EN
  output logic             ovf,
`endif
  output logic             busy
);

  localparam int unsigned N    = cla_seq_steps(WIDTH);
  localparam int unsigned IdxW = cla_seq_idx_w(WIDTH);

  cla_seq_state_e r_state;
  cla_seq_state_e w_state_d;

  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_sum;
  logic [IdxW-1:0]  r_idx;
  logic             r_carry;
  logic             r_cout;
  logic             r_out_valid;
  logic [3:0]       w_slice_sum;
  logic             w_slice_cout;
  logic             w_last;

  cla u_cla (
    .a    (r_a[3:0]),
    .b    (r_b[3:0]),
    .cin  (r_carry),
    .sum  (w_slice_sum),
    .cout (w_slice_cout)
  );

  assign w_last = (r_idx == IdxW'(N - 1));

  always_comb begin
    w_state_d = r_state;
    unique case (r_state)
      StIdle:  if (in_valid) w_state_d = StRun;
      StRun:   if (w_last) w_state_d = StDone;
      StDone:  if (out_ready) w_state_d = StIdle;
      default: w_state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a         <= '0;
      r_b         <= '0;
      r_sum       <= '0;
      r_idx       <= '0;
      r_carry     <= 1'b0;
      r_cout      <= 1'b0;
      r_out_valid <= 1'b0;
    end else begin
      unique case (r_state)
        StIdle: begin
          if (in_valid) begin
            r_a     <= a;
            r_b     <= b;
            r_carry <= cin;
            r_idx   <= '0;
            r_sum   <= '0;
          end
        end
        StRun: begin
          r_sum[r_idx*NIBBLE +: NIBBLE] <= w_slice_sum;
          r_carry <= w_slice_cout;
          r_a     <= r_a >> NIBBLE;
          r_b     <= r_b >> NIBBLE;
          if (w_last) begin
            r_cout      <= w_slice_cout;
            r_out_valid <= 1'b1;
          end else begin
            r_idx <= r_idx + 1'b1;
          end
        end
        StDone: begin
          if (out_ready) r_out_valid <= 1'b0;
        end
        default: r_out_valid <= 1'b0;
      endcase
    end
  end

`ifdef CLA_SEQ_OVF_EN
  logic r_ovf;
  logic w_c_msb;

  // Carry into the top bit recovered from the slice's top sum bit.
  assign w_c_msb = w_slice_sum[3] ^ r_a[3] ^ r_b[3];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ovf <= 1'b0;
    end else if (r_state == StRun && w_last) begin
      r_ovf <= w_c_msb ^ w_slice_cout;
    end
  end

  assign ovf = r_ovf;
`endif

  assign in_ready  = (r_state == StIdle);
  assign busy      = (r_state == StRun) || (r_state == StDone);
  assign out_valid = r_out_valid;
  assign sum       = r_sum;
  assign cout      = r_cout;

endmodule

// File: tb/tb_cla_seq_adder.sv
// Directed self-checking bench for cla_seq_adder at WIDTH=16.
module tb_cla_seq_adder;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] a;
  logic [15:0] b;
  logic        cin;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] sum;
  logic        cout;
  logic        busy;
`ifdef CLA_SEQ_OVF_EN
  logic        ovf;
`endif

  int total = 0;
  int bad   = 0;

  cla_seq_adder #(.WIDTH(16)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout),
`ifdef CLA_SEQ_OVF_EN
    .ovf       (ovf),
`endif
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Present an operation and let the accept edge happen.
  task automatic accept(input logic [15:0] av, input logic [15:0] bv, input logic cv);
    a        = av;
    b        = bv;
    cin      = cv;
    in_valid = 1'b1;
    tick(1);
    in_valid = 1'b0;
  endtask

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    a         = '0;
    b         = '0;
    cin       = 1'b0;
    out_ready = 1'b1;
    #12;
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_sum", 32'(sum), 32'h0000);
    check("rst_cout", 32'(cout), 32'd0);
    rst_n = 1'b1;
    tick(2);
    check("idle_in_ready", 32'(in_ready), 32'd1);
    check("idle_busy", 32'(busy), 32'd0);

    // 0xFFFF + 0x0001: latency exactly 4 cycles from accept
    accept(16'hFFFF, 16'h0001, 1'b0);
    check("t1_busy", 32'(busy), 32'd1);
    check("t1_in_ready_run", 32'(in_ready), 32'd0);
    tick(3);
    check("t1_valid_early", 32'(out_valid), 32'd0);
    tick(1);
    check("t1_valid", 32'(out_valid), 32'd1);
    check("t1_sum", 32'(sum), 32'h0000);
    check("t1_cout", 32'(cout), 32'd1);
`ifdef CLA_SEQ_OVF_EN
    check("t1_ovf", 32'(ovf), 32'd0);
`endif
    tick(1);
    check("t1_idle_ready", 32'(in_ready), 32'd1);
    check("t1_idle_valid", 32'(out_valid), 32'd0);

    // 0x1234 + 0x4321 + 1, with operand churn during RUN
    out_ready = 1'b0;
    accept(16'h1234, 16'h4321, 1'b1);
    a        = 16'hAAAA;
    b        = 16'h5555;
    cin      = 1'b0;
    in_valid = 1'b1;
    tick(1);
    check("t2_in_ready_run", 32'(in_ready), 32'd0);
    tick(3);
    in_valid = 1'b0;
    check("t2_valid", 32'(out_valid), 32'd1);
    check("t2_sum", 32'(sum), 32'h5556);
    check("t2_cout", 32'(cout), 32'd0);
    out_ready = 1'b1;
    tick(1);
    check("t2_idle", 32'(in_ready), 32'd1);

    // Backpressure: result held for 5 cycles
    out_ready = 1'b0;
    accept(16'h8000, 16'h8000, 1'b0);
    tick(4);
    check("t3_valid", 32'(out_valid), 32'd1);
    tick(5);
    check("t3_valid_held", 32'(out_valid), 32'd1);
    check("t3_sum_held", 32'(sum), 32'h0000);
    check("t3_cout_held", 32'(cout), 32'd1);
    check("t3_busy_held", 32'(busy), 32'd1);
    out_ready = 1'b1;
    tick(1);
    check("t3_idle_ready", 32'(in_ready), 32'd1);
    check("t3_idle_valid", 32'(out_valid), 32'd0);

    // Reset two RUN cycles into an operation
    accept(16'hFFFF, 16'hFFFF, 1'b1);
    tick(2);
    rst_n = 1'b0;
    #1;
    check("t4_rst_in_ready", 32'(in_ready), 32'd1);
    check("t4_rst_valid", 32'(out_valid), 32'd0);
    check("t4_rst_busy", 32'(busy), 32'd0);
    check("t4_rst_sum", 32'(sum), 32'h0000);
    check("t4_rst_cout", 32'(cout), 32'd0);
    tick(1);
    rst_n = 1'b1;
    tick(1);
    accept(16'h00FF, 16'h0001, 1'b0);
    tick(4);
    check("t4_valid", 32'(out_valid), 32'd1);
    check("t4_sum", 32'(sum), 32'h0100);
    check("t4_cout", 32'(cout), 32'd0);
    tick(1);

`ifdef CLA_SEQ_OVF_EN
    accept(16'h7FFF, 16'h0001, 1'b0);
    tick(4);
    check("t5_sum", 32'(sum), 32'h8000);
    check("t5_cout", 32'(cout), 32'd0);
    check("t5_ovf", 32'(ovf), 32'd1);
    tick(1);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/cla_seq_adder.md
# cla_seq_adder

Nibble-serial wide adder that shares a single 4-bit carry-lookahead slice over WIDTH/4 cycles to add two WIDTH-bit operands. It accepts one operation through a valid/ready input handshake and sequences the slice one nibble per cycle, LSB first, carrying between nibbles in a register. It presents the result through a valid/ready output handshake. It sits between an operand producer and a result consumer wherever a full-width adder is too costly in area.

## Interface
- WIDTH, 16, operand/sum width; must be a multiple of 4 and ≥ 4; N = WIDTH/4 nibble steps
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  operand request
- in_ready  out  1  block can accept; high only in IDLE
- a  in  WIDTH  operand A, sampled on input handshake
- b  in  WIDTH  operand B, sampled on input handshake
- cin  in  1  carry-in, sampled on input handshake
- out_valid  out  1  result available; high only in DONE
- out_ready  in  1  consumer accepts result
- sum  out  WIDTH  result, stable while out_valid
- cout  out  1  carry out of bit WIDTH-1
- busy  out  1  high in RUN or DONE

## Operation
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid: capture a, b into shift registers, carry←cin, idx←0, sum←0, go to RUN.
- RUN, each cycle:
  - Drive the slice with a[3:0], b[3:0] of the shift registers and the carry register.
  - Write the slice sum into sum nibble idx.
  - carry←slice cout; shift a and b right by 4; idx←idx+1.
  - When idx==N-1 the step completes, cout←slice cout, go to DONE.
- DONE:
  - out_valid=1; sum and cout are held.
  - On out_ready go to IDLE.
- in_valid outside IDLE is ignored, with no capture. Operands may change freely after the accept edge.
- Arithmetic is unsigned modulo 2^WIDTH. cout is the true carry of a+b+cin.
- idx is a ceil(log2(N))-bit counter. No wrap occurs, because the FSM leaves RUN at N-1. For WIDTH=4 the block completes in one RUN cycle.
- Reset values: state=IDLE, in_ready=1 (combinational from state), out_valid=0, busy=0, sum=0, cout=0, carry=0, idx=0.
- rst_n asserted mid-operation aborts immediately. The partial result is discarded and no out_valid is produced.

## Timing
- Accept edge k is the edge where in_valid && in_ready.
- Edges k+1..k+N process nibbles 0..N-1.
- out_valid is high after edge k+N, so latency is N cycles from accept.
- With out_ready held high, IDLE is re-entered at edge k+N+1. The next accept is possible at edge k+N+2, giving a minimum initiation interval of N+2 cycles.
- Backpressure: out_valid stays high and sum/cout stay stable indefinitely until out_ready.
- All outputs are registered except in_ready and busy, which decode the state register.

## Configuration
- CLA_SEQ_OVF_EN defined:
  - Adds output port ovf (out, 1), the signed two's-complement overflow.
  - ovf = carry into bit WIDTH-1 XOR cout, captured on the final RUN cycle.
  - Reset value 0; held in DONE.
- CLA_SEQ_OVF_EN not defined: the ovf port and its logic are absent. All other behaviour is identical.

## Structure
- Package cla_seq_pkg holds:
  - the state typedef (IDLE, RUN, DONE);
  - the NIBBLE=4 constant;
  - a function computing N and the idx width from WIDTH.
- One sub-module: instance of the team's existing 4-bit carry-lookahead adder `cla` (a, b, cin, sum, cout) as the shared slice. No other hierarchy.

## Test plan
All scenarios use WIDTH=16.
- Reset, then idle: in_ready=1, out_valid=0, busy=0, sum=0x0000, cout=0.
- a=0xFFFF, b=0x0001, cin=0 → sum=0x0000, cout=1. out_valid rises exactly 4 cycles after accept.
- a=0x1234, b=0x4321, cin=1 → sum=0x5556, cout=0. Change a/b/in_valid during RUN and check no effect and in_ready=0.
- Backpressure: a=0x8000, b=0x8000, cin=0, out_ready low for 5 cycles → sum=0x0000, cout=1 held stable; IDLE one cycle after out_ready.
- Reset mid-operation: assert rst_n low after 2 RUN cycles → all outputs at reset values immediately. A following op a=0x00FF, b=0x0001 gives sum=0x0100, cout=0.
- With CLA_SEQ_OVF_EN defined:
  - a=0x7FFF, b=0x0001, cin=0 → sum=0x8000, cout=0, ovf=1.
  - a=0xFFFF, b=0x0001 → ovf=0.
